// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
// Pure declarations: no timing and no flow control of its own.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   function automatic logic is_div(op_t op);
      return op[2];
   endfunction

   function automatic logic is_signed_a(op_t op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(op_t op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: shift-add multiply step or restoring divide step.
// Purely combinational, zero latency; no flow control, the sequencer decides when to use it.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              div_mode,
   input  logic [2*XLEN-1:0] acc,
   input  logic [2*XLEN-1:0] mcand,
   input  logic [XLEN-1:0]   opb,
   output logic [2*XLEN-1:0] acc_nxt,
   output logic [2*XLEN-1:0] mcand_nxt,
   output logic [XLEN-1:0]   opb_nxt
);

   logic [XLEN:0]   partial;
   logic [XLEN-1:0] diff;
   logic            ge;

   // Divide layout: acc = {remainder, dividend/quotient}; next dividend bit is acc[XLEN-1].
   always_comb begin
      partial   = acc[2*XLEN-1:XLEN-1];
      ge        = (partial >= {1'b0, opb});
      diff      = partial[XLEN-1:0] - opb;
      acc_nxt   = acc;
      mcand_nxt = mcand;
      opb_nxt   = opb;
      if (div_mode) begin
         acc_nxt = {(ge ? diff : partial[XLEN-1:0]), acc[XLEN-2:0], ge};
      end else begin
         acc_nxt   = acc + (opb[0] ? mcand : '0);
         mcand_nxt = mcand << 1;
         opb_nxt   = opb >> 1;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M mul/div beside the E-stage ALU; result valid XLEN+1 cycles after accept (2 for divide-by-zero).
// Stalls F/D/E combinationally from accept until the DONE cycle; flush kills the op with no result pulse.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter  int XLEN  = 32,
   localparam int CNT_W = $clog2(XLEN+1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StartE_i,
   input  logic [2:0]      OpE_i,
   input  logic [XLEN-1:0] SrcAE_i,
   input  logic [XLEN-1:0] SrcBE_i,
   input  logic            FlushE_i,
   output logic            StallE_o,
   output logic            ValidE_o,
   output logic [XLEN-1:0] ResultE_o
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [2*XLEN-1:0] acc_q, mcand_q;
   logic [XLEN-1:0]   opb_q;
   op_t               op_q;
   logic              neg_res_q, neg_rem_q, dz_q;
   logic [XLEN-1:0]   result_q;

   op_t               op_in;
   logic              accept, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] acc_nxt, mcand_nxt, prod;
   logic [XLEN-1:0]   opb_nxt, quo, rem_mag, fix_res;

   assign op_in  = op_t'(OpE_i);
   assign accept = StartE_i && !FlushE_i && ((state_q == IDLE) || (state_q == DONE));
   assign a_neg  = is_signed_a(op_in) && SrcAE_i[XLEN-1];
   assign b_neg  = is_signed_b(op_in) && SrcBE_i[XLEN-1];
   assign a_mag  = a_neg ? -SrcAE_i : SrcAE_i;
   assign b_mag  = b_neg ? -SrcBE_i : SrcBE_i;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .div_mode  (is_div(op_q)),
      .acc       (acc_q),
      .mcand     (mcand_q),
      .opb       (opb_q),
      .acc_nxt   (acc_nxt),
      .mcand_nxt (mcand_nxt),
      .opb_nxt   (opb_nxt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = BUSY;
         BUSY:    if (dz_q || (cnt_q == CNT_W'(XLEN-1))) state_d = DONE;
         DONE:    state_d = accept ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
      if (FlushE_i) state_d = IDLE;
   end

   // Divide-by-zero never iterates, so the dividend magnitude is still in the low half.
   always_comb begin
      prod    = neg_res_q ? -acc_q : acc_q;
      quo     = acc_q[XLEN-1:0];
      rem_mag = dz_q ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
      fix_res = '0;
      case (op_q)
         OP_MUL:                      fix_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             fix_res = dz_q ? '1 : (neg_res_q ? -quo : quo);
         OP_REM, OP_REMU:             fix_res = neg_rem_q ? -rem_mag : rem_mag;
         default:                     fix_res = '0;
      endcase
   end

   assign StallE_o  = accept || (state_q == BUSY);
   assign ValidE_o  = (state_q == DONE);
   assign ResultE_o = ValidE_o ? fix_res : result_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         opb_q     <= '0;
         op_q      <= OP_MUL;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q     <= '0;
            acc_q     <= is_div(op_in) ? {{XLEN{1'b0}}, a_mag} : '0;
            mcand_q   <= {{XLEN{1'b0}}, a_mag};
            opb_q     <= b_mag;
            op_q      <= op_in;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= is_div(op_in) && (SrcBE_i == '0);
         end else if ((state_q == BUSY) && !dz_q) begin
            acc_q   <= acc_nxt;
            mcand_q <= mcand_nxt;
            opb_q   <= opb_nxt;
            if (cnt_q != CNT_W'(XLEN-1)) cnt_q <= cnt_q + CNT_W'(1);
         end
         if (state_q == DONE) result_q <= fix_res;
      end
   end

endmodule
